// File: rtl/edge_pkg.sv
// Shared types and the mode qualification helper for the edge detector bank.
package edge_pkg;

   typedef enum logic [1:0] {
      EDGE_OFF  = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_t;

   function automatic logic qualify(edge_mode_t mode, logic pos, logic neg);
      logic q;
      case (mode)
         EDGE_RISE: q = pos;
         EDGE_FALL: q = neg;
         EDGE_BOTH: q = pos | neg;
         default:   q = 1'b0;
      endcase
      return q;
   endfunction

endpackage

// File: rtl/edge_channel.sv
// One channel: synchroniser, debounce filter and registered edge pulses.
module edge_channel #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEBOUNCE    = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic positive_edge,
   output logic negative_edge
);

   localparam int unsigned CntW = $clog2(DEBOUNCE + 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   filt_q, filt_d;
   logic                   prev_q;
   logic                   pos_q, pos_d;
   logic                   neg_q, neg_d;
   logic                   s;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], in};
      s      = sync_q[SYNC_STAGES-1];
      filt_d = filt_q;
      cnt_d  = '0;
      // The counter only runs while the synchronised level disagrees with the filtered one.
      if (s != filt_q) begin
         if (cnt_q == CntW'(DEBOUNCE - 1)) begin
            filt_d = s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      pos_d = filt_q & ~prev_q;
      neg_d = ~filt_q & prev_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         cnt_q  <= '0;
         filt_q <= 1'b0;
         prev_q <= 1'b0;
         pos_q  <= 1'b0;
         neg_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
         prev_q <= filt_q;
         pos_q  <= pos_d;
         neg_q  <= neg_d;
      end
   end

   assign positive_edge = pos_q;
   assign negative_edge = neg_q;

endmodule

// File: rtl/edge_detector_bank.sv
// N-channel edge detector with per-channel mode, sticky pending flags and a
// saturating shared event counter.
module edge_detector_bank
   import edge_pkg::*;
#(
   parameter int unsigned N           = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEBOUNCE    = 3,
   parameter int unsigned COUNT_W     = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       in,
   input  logic [2*N-1:0]     mode,
   input  logic [N-1:0]       clear,
   input  logic               count_clear,
   output logic [N-1:0]       positive_edge,
   output logic [N-1:0]       negative_edge,
   output logic [N-1:0]       pending,
   output logic               any_pending,
   output logic [COUNT_W-1:0] event_count
);

   localparam int unsigned PopW = $clog2(N + 1);
   localparam int unsigned SumW = COUNT_W + 1;

   logic [N-1:0]       qual;
   logic [PopW-1:0]    pop;
   logic [N-1:0]       pending_q, pending_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic [COUNT_W-1:0] base;
   logic [SumW-1:0]    sum;

   for (genvar g = 0; g < N; g++) begin : g_chan
      edge_channel #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEBOUNCE    (DEBOUNCE)
      ) u_chan (
         .clk           (clk),
         .rst           (rst),
         .in            (in[g]),
         .positive_edge (positive_edge[g]),
         .negative_edge (negative_edge[g])
      );
   end

   always_comb begin
      qual = '0;
      pop  = '0;
      for (int i = 0; i < N; i++) begin
         qual[i] = qualify(edge_mode_t'(mode[2*i +: 2]), positive_edge[i], negative_edge[i]);
         pop     = pop + PopW'(qual[i]);
      end
   end

   // A new event outranks a clear arriving in the same cycle.
   assign pending_d = (pending_q & ~clear) | qual;

   always_comb begin
      base = count_clear ? '0 : count_q;
      sum  = {1'b0, base} + SumW'(pop);
      if (sum[COUNT_W]) begin
         count_d = '1;
      end else begin
         count_d = sum[COUNT_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= '0;
         count_q   <= '0;
      end else begin
         pending_q <= pending_d;
         count_q   <= count_d;
      end
   end

   assign pending     = pending_q;
   assign any_pending = |pending_q;
   assign event_count = count_q;

endmodule
